rv32_dmem_ahb_ctrl: RTL and testbench

//  Sequences RV32I data-memory loads/stores onto a single-master AHB-Lite bus.

---
 rtl/rv32_dmem_ahb_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_rv32_dmem_ahb_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_dmem_ahb_ctrl.sv
// RV32I data-memory controller: turns one core load/store into a single AHB-Lite
// NONSEQ transfer, stalls the pipeline while busy and extends load data.
module rv32_dmem_ahb_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rd_req_in,
    input  logic        wr_req_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic [3:0]  wr_mask_in,
    output logic [31:0] haddr_out,
    output logic [1:0]  htrans_out,
    output logic        hwrite_out,
    output logic [2:0]  hsize_out,
    output logic [31:0] hwdata_out,
    output logic [3:0]  hwstrb_out,
    input  logic [31:0] hrdata_in,
    input  logic        hready_in,
    input  logic        hresp_in,
    output logic        stall_out,
    output logic [31:0] rdata_out,
    output logic        done_out,
    output logic        bus_err_out,
    output logic        misalign_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ADDR = 2'b01,
        S_DATA = 2'b10
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [7:0] TIMEOUT_CNT   = 8'(TIMEOUT);

    state_t      state, state_next;

    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;
    logic [3:0]  mask_q;
    logic        write_q;
    logic [7:0]  wait_cnt, wait_cnt_next;
    logic        done_q, bus_err_q, misalign_q;
    logic [31:0] rdata_q;

    logic        req;
    logic        misaligned;
    logic        capture;
    logic        done_set, err_set, misalign_set, rdata_load;
    logic [7:0]  stalled_cnt;
    logic        timeout_hit;
    logic [31:0] lane_shifted;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;

    assign req = rd_req_in | wr_req_in;

    // Halfwords need addr[0]==0, words need addr[1:0]==0; bytes are always aligned.
    assign misaligned = ((funct3_in[1:0] == 2'b01) & addr_in[0]) |
                        ((funct3_in[1:0] == 2'b10) & (addr_in[1:0] != 2'b00));

    assign stalled_cnt = wait_cnt + 8'd1;
    assign timeout_hit = (stalled_cnt == TIMEOUT_CNT);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        capture       = 1'b0;
        done_set      = 1'b0;
        err_set       = 1'b0;
        misalign_set  = 1'b0;
        rdata_load    = 1'b0;
        case (state)
            S_IDLE: begin
                wait_cnt_next = '0;
                if (req) begin
                    capture = 1'b1;
                    if (misaligned) begin
                        misalign_set = 1'b1;
                    end else begin
                        state_next = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (hready_in) begin
                    wait_cnt_next = '0;
                    state_next    = S_DATA;
                end else if (timeout_hit) begin
                    wait_cnt_next = '0;
                    err_set       = 1'b1;
                    state_next    = S_IDLE;
                end else begin
                    wait_cnt_next = stalled_cnt;
                end
            end
            S_DATA: begin
                if (hready_in) begin
                    wait_cnt_next = '0;
                    state_next    = S_IDLE;
                    if (hresp_in) begin
                        err_set = 1'b1;
                    end else begin
                        done_set   = 1'b1;
                        rdata_load = ~write_q;
                    end
                end else if (timeout_hit) begin
                    wait_cnt_next = '0;
                    err_set       = 1'b1;
                    state_next    = S_IDLE;
                end else begin
                    wait_cnt_next = stalled_cnt;
                end
            end
            default: begin
                wait_cnt_next = '0;
                state_next    = S_IDLE;
            end
        endcase
    end

    // Lane extraction works on the captured address, since the core may change addr_in meanwhile.
    always_comb begin
        lane_shifted = hrdata_in >> {addr_q[1:0], 3'b000};
        load_byte    = lane_shifted[7:0];
        load_half    = addr_q[1] ? hrdata_in[31:16] : hrdata_in[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b100:  load_ext = {24'd0, load_byte};
            3'b101:  load_ext = {16'd0, load_half};
            default: load_ext = hrdata_in;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_q   <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
            write_q  <= 1'b0;
        end else if (capture) begin
            addr_q   <= addr_in;
            funct3_q <= funct3_in;
            wdata_q  <= wdata_in;
            mask_q   <= wr_mask_in;
            write_q  <= wr_req_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wait_cnt   <= '0;
            done_q     <= 1'b0;
            bus_err_q  <= 1'b0;
            misalign_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            wait_cnt   <= wait_cnt_next;
            done_q     <= done_set;
            bus_err_q  <= err_set;
            misalign_q <= misalign_set;
            if (rdata_load) begin
                rdata_q <= load_ext;
            end
        end
    end

    assign htrans_out   = (state == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr_out    = addr_q;
    assign hwrite_out   = write_q;
    assign hsize_out    = {1'b0, funct3_q[1:0]};
    assign hwdata_out   = ((state == S_DATA) && write_q) ? wdata_q : '0;
    assign hwstrb_out   = ((state == S_DATA) && write_q) ? mask_q : '0;

    // Stall rises combinationally with an aligned request; gated by reset so outputs read 0 in reset.
    assign stall_out    = rst_n_in & (((state == S_IDLE) & req & ~misaligned) | (state != S_IDLE));

    assign rdata_out    = rdata_q;
    assign done_out     = done_q;
    assign bus_err_out  = bus_err_q;
    assign misalign_out = misalign_q;

endmodule

// File: tb/tb_rv32_dmem_ahb_ctrl.sv
// Bench for rv32_dmem_ahb_ctrl: directed spec scenarios then randomized accesses,
// checked against a transaction-level model of the expected bus/core behaviour.
module tb_rv32_dmem_ahb_ctrl;

    localparam int TO = 4;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rd_req_in, wr_req_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in, wdata_in;
    logic [3:0]  wr_mask_in;
    logic [31:0] haddr_out;
    logic [1:0]  htrans_out;
    logic        hwrite_out;
    logic [2:0]  hsize_out;
    logic [31:0] hwdata_out;
    logic [3:0]  hwstrb_out;
    logic [31:0] hrdata_in;
    logic        hready_in, hresp_in;
    logic        stall_out;
    logic [31:0] rdata_out;
    logic        done_out, bus_err_out, misalign_out;

    rv32_dmem_ahb_ctrl #(.TIMEOUT(TO)) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .rd_req_in   (rd_req_in),
        .wr_req_in   (wr_req_in),
        .funct3_in   (funct3_in),
        .addr_in     (addr_in),
        .wdata_in    (wdata_in),
        .wr_mask_in  (wr_mask_in),
        .haddr_out   (haddr_out),
        .htrans_out  (htrans_out),
        .hwrite_out  (hwrite_out),
        .hsize_out   (hsize_out),
        .hwdata_out  (hwdata_out),
        .hwstrb_out  (hwstrb_out),
        .hrdata_in   (hrdata_in),
        .hready_in   (hready_in),
        .hresp_in    (hresp_in),
        .stall_out   (stall_out),
        .rdata_out   (rdata_out),
        .done_out    (done_out),
        .bus_err_out (bus_err_out),
        .misalign_out(misalign_out)
    );

    always #5 clk_in = ~clk_in;

    int          checks = 0;
    int          errors = 0;
    string       cur = "init";
    logic [31:0] model_rdata = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%h expected=%h", cur, tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    // Load result from the architectural rules: pick the lane, then sign- or zero-extend numerically.
    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] d);
        longint v;
        case (f3)
            3'b000, 3'b100: begin
                v = (d >> (8 * a[1:0])) & 32'hff;
                if (f3 == 3'b000 && v >= 128) v = v - 256;
            end
            3'b001, 3'b101: begin
                v = (d >> (16 * a[1])) & 32'hffff;
                if (f3 == 3'b001 && v >= 32768) v = v - 65536;
            end
            default: v = longint'(d);
        endcase
        return v[31:0];
    endfunction

    task automatic scramble_core();
        rd_req_in  = 1'($urandom_range(0, 1));
        wr_req_in  = 1'($urandom_range(0, 1));
        funct3_in  = 3'($urandom);
        addr_in    = $urandom;
        wdata_in   = $urandom;
        wr_mask_in = 4'($urandom);
    endtask

    task automatic run_access(input string name, input bit wr, input bit both, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m,
                              input logic [31:0] rd, input int wa, input int wdw, input bit err);
        bit mis, aborted;
        int stalled;
        cur = name;
        mis = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
        aborted = 1'b0;
        rd_req_in = !wr || both;
        wr_req_in = wr;
        funct3_in = f3;
        addr_in = a;
        wdata_in = wd;
        wr_mask_in = m;
        hrdata_in = rd;
        hready_in = 1'b1;
        hresp_in = 1'b0;
        @(negedge clk_in);
        check("req_stall", 32'(stall_out), 32'(!mis));
        check("req_htrans", 32'(htrans_out), 32'd0);
        next_cycle();
        if (!mis) begin
            stalled = 0;
            for (int i = 0; i <= wa && !aborted; i++) begin
                scramble_core();
                hready_in = (i == wa);
                hresp_in = 1'b0;
                @(negedge clk_in);
                check("a_htrans", 32'(htrans_out), 32'd2);
                check("a_haddr", haddr_out, a);
                check("a_hwrite", 32'(hwrite_out), 32'(wr));
                check("a_hsize", 32'(hsize_out), 32'(f3[1:0]));
                check("a_stall", 32'(stall_out), 32'd1);
                check("a_done", 32'({done_out, bus_err_out, misalign_out}), 32'd0);
                next_cycle();
                if (!hready_in) begin
                    stalled++;
                    if (stalled == TO) aborted = 1'b1;
                end
            end
            stalled = 0;
            for (int j = 0; j <= wdw && !aborted; j++) begin
                scramble_core();
                hready_in = (j == wdw);
                hresp_in = err && (j >= wdw - 1);
                @(negedge clk_in);
                check("d_htrans", 32'(htrans_out), 32'd0);
                check("d_hwdata", hwdata_out, wr ? wd : 32'd0);
                check("d_hwstrb", 32'(hwstrb_out), wr ? 32'(m) : 32'd0);
                check("d_stall", 32'(stall_out), 32'd1);
                check("d_done", 32'({done_out, bus_err_out, misalign_out}), 32'd0);
                next_cycle();
                if (!hready_in) begin
                    stalled++;
                    if (stalled == TO) aborted = 1'b1;
                end
            end
        end
        rd_req_in = 1'b0;
        wr_req_in = 1'b0;
        hready_in = 1'b1;
        hresp_in = 1'b0;
        @(negedge clk_in);
        if (mis) begin
            check("r_flags", 32'({done_out, bus_err_out, misalign_out}), 32'b001);
        end else if (aborted || err) begin
            check("r_flags", 32'({done_out, bus_err_out, misalign_out}), 32'b010);
        end else begin
            check("r_flags", 32'({done_out, bus_err_out, misalign_out}), 32'b100);
            if (!wr) model_rdata = load_model(f3, a, rd);
        end
        check("r_rdata", rdata_out, model_rdata);
        check("r_htrans", 32'(htrans_out), 32'd0);
        check("r_stall", 32'(stall_out), 32'd0);
        next_cycle();
        @(negedge clk_in);
        check("after_flags", 32'({done_out, bus_err_out, misalign_out}), 32'd0);
        next_cycle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_htrans"}, 32'(htrans_out), 32'd0);
        check({tag, "_haddr"}, haddr_out, 32'd0);
        check({tag, "_hctl"}, 32'({hwrite_out, hsize_out, hwstrb_out}), 32'd0);
        check({tag, "_hwdata"}, hwdata_out, 32'd0);
        check({tag, "_rdata"}, rdata_out, 32'd0);
        check({tag, "_flags"}, 32'({stall_out, done_out, bus_err_out, misalign_out}), 32'd0);
    endtask

    initial begin
        logic [2:0] load_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst_n_in = 1'b0;
        rd_req_in = 1'b0;
        wr_req_in = 1'b0;
        funct3_in = '0;
        addr_in = '0;
        wdata_in = '0;
        wr_mask_in = '0;
        hrdata_in = '0;
        hready_in = 1'b1;
        hresp_in = 1'b0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        cur = "reset";
        check_all_zero("rst");
        rst_n_in = 1'b1;
        next_cycle();

        run_access("lw", 0, 0, 3'b010, 32'h100, 0, 0, 32'hDEADBEEF, 0, 0, 0);
        check("lw_const", rdata_out, 32'hDEADBEEF);
        run_access("lb", 0, 0, 3'b000, 32'h103, 0, 0, 32'h80000000, 0, 0, 0);
        check("lb_const", rdata_out, 32'hFFFFFF80);
        run_access("lbu", 0, 0, 3'b100, 32'h103, 0, 0, 32'h80000000, 0, 0, 0);
        check("lbu_const", rdata_out, 32'h00000080);
        run_access("lhu", 0, 0, 3'b101, 32'h102, 0, 0, 32'h80000000, 0, 0, 0);
        check("lhu_const", rdata_out, 32'h00008000);
        run_access("lh", 0, 0, 3'b001, 32'h100, 0, 0, 32'h1234F00D, 1, 0, 0);
        check("lh_const", rdata_out, 32'hFFFFF00D);
        run_access("sh", 1, 0, 3'b001, 32'h202, 32'hABCD0000, 4'b1100, 32'h0, 0, 3, 0);
        check("sh_keeps_rdata", rdata_out, 32'hFFFFF00D);
        run_access("lw_mis", 0, 0, 3'b010, 32'h301, 0, 0, 32'h0, 0, 0, 0);
        run_access("sh_mis", 1, 0, 3'b001, 32'h201, 32'h1, 4'b0011, 32'h0, 0, 0, 0);
        run_access("both_sb", 1, 1, 3'b000, 32'h205, 32'h0000AA00, 4'b0010, 32'h0, 0, 0, 0);
        run_access("lw_err", 0, 0, 3'b010, 32'h104, 0, 0, 32'h55555555, 0, 1, 1);
        check("err_keeps_rdata", rdata_out, 32'hFFFFF00D);
        run_access("to_data", 0, 0, 3'b010, 32'h108, 0, 0, 32'h66666666, 0, 10, 0);
        run_access("to_addr", 1, 0, 3'b010, 32'h10C, 32'h77, 4'hF, 32'h0, 6, 0, 0);
        run_access("wait3_ok", 0, 0, 3'b010, 32'h110, 0, 0, 32'hCAFEF00D, 3, 3, 0);

        for (int n = 0; n < 60; n++) begin
            bit         wr, both, err;
            logic [2:0] f3;
            logic [31:0] a;
            int         wa, wdw;
            wr = 1'($urandom_range(0, 1));
            both = wr && ($urandom_range(0, 3) == 0);
            f3 = wr ? 3'($urandom_range(0, 2)) : load_f3[$urandom_range(0, 4)];
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            wa = ($urandom_range(0, 9) == 0) ? TO + 1 : int'($urandom_range(0, 2));
            wdw = ($urandom_range(0, 9) == 0) ? TO + 2 : int'($urandom_range(0, 2));
            err = ($urandom_range(0, 5) == 0);
            run_access($sformatf("rand%0d", n), wr, both, f3, a, $urandom, 4'($urandom),
                       $urandom, wa, wdw, err);
        end

        cur = "rst_mid";
        wr_req_in = 1'b1;
        funct3_in = 3'b010;
        addr_in = 32'h400;
        wdata_in = 32'h12345678;
        wr_mask_in = 4'hF;
        next_cycle();
        wr_req_in = 1'b0;
        next_cycle();
        hready_in = 1'b0;
        @(negedge clk_in);
        check("pre_hwdata", hwdata_out, 32'h12345678);
        #1;
        rst_n_in = 1'b0;
        #1;
        check_all_zero("rst_mid");
        #3;
        rst_n_in = 1'b1;
        model_rdata = '0;
        hready_in = 1'b1;
        next_cycle();
        run_access("post_rst", 0, 0, 3'b000, 32'h501, 0, 0, 32'h00007F00, 0, 0, 0);
        check("post_rst_const", rdata_out, 32'h0000007F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
